// File: rtl/rr_arb_16.sv
// rr_arb_16: round-robin arbiter and sequencer for a 16:1 DMA data mux.
// One requester owns the 64-bit channel for a whole packet; priority rotates on release.
module rr_arb_16 #(
    parameter int DATA_W    = 64,
    parameter int MAX_BEATS = 256
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [15:0]          req,
    input  logic [15:0]          last,
    input  logic [16*DATA_W-1:0] data,
    output logic [15:0]          gnt,
    output logic [3:0]           sel,
    output logic                 out_valid,
    output logic [DATA_W-1:0]    out_data,
    output logic                 out_last,
    input  logic                 out_ready,
    output logic                 busy,
    output logic                 preempt
);

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    localparam logic [15:0] LIMIT = 16'(MAX_BEATS - 1);

    state_t      state;
    state_t      state_next;
    logic [3:0]  ptr;
    logic [3:0]  owner;
    logic [3:0]  winner;
    logic [15:0] beats;
    logic        found;
    logic        transfer;
    logic        at_limit;
    logic        pkt_done;

    // Rotating priority scan: first set request starting at ptr, wrapping past 15.
    always_comb begin
        winner = ptr;
        found  = 1'b0;
        for (int k = 0; k < 16; k++) begin
            if (!found && req[ptr + 4'(k)]) begin
                winner = ptr + 4'(k);
                found  = 1'b1;
            end
        end
    end

    assign sel       = owner;
    assign busy      = (state == GRANT);
    assign out_valid = (state == GRANT) && req[owner];
    assign out_last  = (state == GRANT) && last[owner];
    assign out_data  = data[owner*DATA_W +: DATA_W];

    assign transfer  = out_valid && out_ready;
    assign at_limit  = (beats == LIMIT);
    assign pkt_done  = transfer && (last[owner] || at_limit);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (found)    state_next = GRANT;
            GRANT:   if (pkt_done) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // A stalled or missing beat leaves everything untouched, so the grant can be held indefinitely.
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr     <= 4'd0;
            owner   <= 4'd0;
            beats   <= 16'd0;
            gnt     <= 16'd0;
            preempt <= 1'b0;
        end else begin
            preempt <= 1'b0;
            if (state == IDLE) begin
                if (found) begin
                    owner <= winner;
                    gnt   <= 16'd1 << winner;
                    beats <= 16'd0;
                end
            end else if (transfer) begin
                beats <= beats + 16'd1;
                if (pkt_done) begin
                    ptr     <= owner + 4'd1;
                    gnt     <= 16'd0;
                    preempt <= at_limit && !last[owner];
                end
            end
        end
    end

endmodule

// File: tb/tb_rr_arb_16.sv
// tb_rr_arb_16: directed checks of rr_arb_16 with MAX_BEATS=4 (table vectors plus hand sequences).
module tb_rr_arb_16;

    localparam int DW = 64;
    localparam int MB = 4;

    logic             clk = 1'b0;
    logic             rst;
    logic [15:0]      req;
    logic [15:0]      last;
    logic [16*DW-1:0] data;
    logic             out_ready;
    logic [15:0]      gnt;
    logic [3:0]       sel;
    logic             out_valid;
    logic [DW-1:0]    out_data;
    logic             out_last;
    logic             busy;
    logic             preempt;

    int n_cmp  = 0;
    int n_fail = 0;

    typedef struct {
        logic        chk;
        logic        rst;
        logic [15:0] req;
        logic [15:0] last;
        logic        ready;
        logic [15:0] tag;
        logic [15:0] e_gnt;
        logic [3:0]  e_sel;
        logic        e_valid;
        logic        e_last;
        logic        e_busy;
        logic        e_pre;
        logic [3:0]  e_ptr;
    } vec_t;

    rr_arb_16 #(.DATA_W(DW), .MAX_BEATS(MB)) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .last      (last),
        .data      (data),
        .gnt       (gnt),
        .sel       (sel),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_last  (out_last),
        .out_ready (out_ready),
        .busy      (busy),
        .preempt   (preempt)
    );

    always #5 clk = ~clk;

    function automatic logic [DW-1:0] word(input logic [3:0] idx, input logic [15:0] tag);
        return {12'h000, idx, 32'hCAFE_0000, tag};
    endfunction

    task automatic applyStimulus(input logic r, input logic [15:0] rq, input logic [15:0] ls,
                                 input logic rdy, input logic [15:0] tag);
        rst       = r;
        req       = rq;
        last      = ls;
        out_ready = rdy;
        for (int i = 0; i < 16; i++) data[i*DW +: DW] = word(4'(i), tag);
    endtask

    task automatic checkOutput(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    task automatic checkCore(input string nm, input logic [15:0] eg, input logic [3:0] es,
                             input logic ev, input logic el, input logic eb, input logic ep);
        checkOutput({nm, " gnt"}, 64'(gnt), 64'(eg));
        checkOutput({nm, " sel"}, 64'(sel), 64'(es));
        checkOutput({nm, " out_valid"}, 64'(out_valid), 64'(ev));
        checkOutput({nm, " out_last"}, 64'(out_last), 64'(el));
        checkOutput({nm, " busy"}, 64'(busy), 64'(eb));
        checkOutput({nm, " preempt"}, 64'(preempt), 64'(ep));
    endtask

    task automatic step(input string nm, input logic r, input logic [15:0] rq, input logic [15:0] ls,
                        input logic rdy, input logic [15:0] tag, input logic [15:0] eg,
                        input logic [3:0] es, input logic ev, input logic el, input logic eb,
                        input logic ep);
        applyStimulus(r, rq, ls, rdy, tag);
        #1;
        checkCore(nm, eg, es, ev, el, eb, ep);
    endtask

    task automatic doReset();
        applyStimulus(1'b1, 16'h0000, 16'h0000, 1'b1, 16'h0000);
        @(negedge clk);
    endtask

    initial begin
        vec_t vecs[15];

        // Single requester 4: three beats, then release and rotation of ptr to 5.
        vecs[0]  = '{1'b1, 1'b0, 16'h0010, 16'h0000, 1'b1, 16'd1,  16'h0000, 4'd0,  1'b0, 1'b0, 1'b0, 1'b0, 4'd0};
        vecs[1]  = '{1'b1, 1'b0, 16'h0010, 16'h0000, 1'b1, 16'd2,  16'h0010, 4'd4,  1'b1, 1'b0, 1'b1, 1'b0, 4'd0};
        vecs[2]  = '{1'b1, 1'b0, 16'h0010, 16'h0000, 1'b1, 16'd3,  16'h0010, 4'd4,  1'b1, 1'b0, 1'b1, 1'b0, 4'd0};
        vecs[3]  = '{1'b1, 1'b0, 16'h0010, 16'h0010, 1'b1, 16'd4,  16'h0010, 4'd4,  1'b1, 1'b1, 1'b1, 1'b0, 4'd0};
        vecs[4]  = '{1'b1, 1'b0, 16'h0000, 16'h0000, 1'b1, 16'd5,  16'h0000, 4'd4,  1'b0, 1'b0, 1'b0, 1'b0, 4'd5};
        vecs[5]  = '{1'b0, 1'b1, 16'h0000, 16'h0000, 1'b1, 16'd0,  16'h0000, 4'd0,  1'b0, 1'b0, 1'b0, 1'b0, 4'd0};
        // Requesters 0 and 15 with one-beat packets: 0, 15, 0, 15 with a bubble between grants.
        vecs[6]  = '{1'b1, 1'b0, 16'h8001, 16'hFFFF, 1'b1, 16'd6,  16'h0000, 4'd0,  1'b0, 1'b0, 1'b0, 1'b0, 4'd0};
        vecs[7]  = '{1'b1, 1'b0, 16'h8001, 16'hFFFF, 1'b1, 16'd7,  16'h0001, 4'd0,  1'b1, 1'b1, 1'b1, 1'b0, 4'd0};
        vecs[8]  = '{1'b1, 1'b0, 16'h8001, 16'hFFFF, 1'b1, 16'd8,  16'h0000, 4'd0,  1'b0, 1'b0, 1'b0, 1'b0, 4'd1};
        vecs[9]  = '{1'b1, 1'b0, 16'h8001, 16'hFFFF, 1'b1, 16'd9,  16'h8000, 4'd15, 1'b1, 1'b1, 1'b1, 1'b0, 4'd1};
        vecs[10] = '{1'b1, 1'b0, 16'h8001, 16'hFFFF, 1'b1, 16'd10, 16'h0000, 4'd15, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0};
        vecs[11] = '{1'b1, 1'b0, 16'h8001, 16'hFFFF, 1'b1, 16'd11, 16'h0001, 4'd0,  1'b1, 1'b1, 1'b1, 1'b0, 4'd0};
        vecs[12] = '{1'b1, 1'b0, 16'h8001, 16'hFFFF, 1'b1, 16'd12, 16'h0000, 4'd0,  1'b0, 1'b0, 1'b0, 1'b0, 4'd1};
        vecs[13] = '{1'b1, 1'b0, 16'h8001, 16'hFFFF, 1'b1, 16'd13, 16'h8000, 4'd15, 1'b1, 1'b1, 1'b1, 1'b0, 4'd1};
        vecs[14] = '{1'b1, 1'b0, 16'h0000, 16'h0000, 1'b1, 16'd14, 16'h0000, 4'd15, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0};

        applyStimulus(1'b1, 16'h0000, 16'h0000, 1'b0, 16'h0000);
        @(negedge clk);
        @(negedge clk);
        step("reset", 1'b0, 16'h0000, 16'h0000, 1'b1, 16'h0000, 16'h0000, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        checkOutput("reset ptr", 64'(dut.ptr), 64'd0);
        checkOutput("reset beats", 64'(dut.beats), 64'd0);
        @(negedge clk);

        for (int i = 0; i < 15; i++) begin
            applyStimulus(vecs[i].rst, vecs[i].req, vecs[i].last, vecs[i].ready, vecs[i].tag);
            #1;
            if (vecs[i].chk) begin
                checkCore($sformatf("row%0d", i), vecs[i].e_gnt, vecs[i].e_sel, vecs[i].e_valid,
                          vecs[i].e_last, vecs[i].e_busy, vecs[i].e_pre);
                checkOutput($sformatf("row%0d ptr", i), 64'(dut.ptr), 64'(vecs[i].e_ptr));
                if (vecs[i].e_valid)
                    checkOutput($sformatf("row%0d out_data", i), out_data, word(vecs[i].e_sel, vecs[i].tag));
            end
            @(negedge clk);
        end

        // Backpressure: owner 2 stalls 5 cycles after its first beat; beats 1..3 follow unchanged.
        doReset();
        step("bp idle", 1'b0, 16'h0004, 16'h0000, 1'b1, 16'd0, 16'h0000, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        step("bp beat0", 1'b0, 16'h0004, 16'h0000, 1'b1, 16'd0, 16'h0004, 4'd2, 1'b1, 1'b0, 1'b1, 1'b0);
        checkOutput("bp beat0 data", out_data, word(4'd2, 16'd0));
        @(negedge clk);
        for (int k = 0; k < 5; k++) begin
            step($sformatf("bp stall%0d", k), 1'b0, 16'h0004, 16'h0000, 1'b0, 16'd1,
                 16'h0004, 4'd2, 1'b1, 1'b0, 1'b1, 1'b0);
            checkOutput($sformatf("bp stall%0d data", k), out_data, word(4'd2, 16'd1));
            checkOutput($sformatf("bp stall%0d beats", k), 64'(dut.beats), 64'd1);
            @(negedge clk);
        end
        for (int k = 1; k < 4; k++) begin
            step($sformatf("bp beat%0d", k), 1'b0, 16'h0004, (k == 3) ? 16'h0004 : 16'h0000, 1'b1,
                 16'(k), 16'h0004, 4'd2, 1'b1, (k == 3), 1'b1, 1'b0);
            checkOutput($sformatf("bp beat%0d data", k), out_data, word(4'd2, 16'(k)));
            checkOutput($sformatf("bp beat%0d beats", k), 64'(dut.beats), 64'(k));
            @(negedge clk);
        end
        step("bp done", 1'b0, 16'h0000, 16'h0000, 1'b1, 16'd0, 16'h0000, 4'd2, 1'b0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);

        // Preemption: requester 7 streams without last, limit forces release, 8 wins next.
        doReset();
        step("pre idle", 1'b0, 16'h0180, 16'h0000, 1'b1, 16'd0, 16'h0000, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        for (int k = 0; k < 4; k++) begin
            step($sformatf("pre beat%0d", k), 1'b0, 16'h0180, 16'h0000, 1'b1, 16'(k),
                 16'h0080, 4'd7, 1'b1, 1'b0, 1'b1, 1'b0);
            checkOutput($sformatf("pre beat%0d beats", k), 64'(dut.beats), 64'(k));
            @(negedge clk);
        end
        step("pre pulse", 1'b0, 16'h0180, 16'h0000, 1'b1, 16'd0, 16'h0000, 4'd7, 1'b0, 1'b0, 1'b0, 1'b1);
        checkOutput("pre pulse ptr", 64'(dut.ptr), 64'd8);
        @(negedge clk);
        step("pre next8", 1'b0, 16'h0180, 16'h0100, 1'b1, 16'd0, 16'h0100, 4'd8, 1'b1, 1'b1, 1'b1, 1'b0);
        @(negedge clk);
        step("pre after8", 1'b0, 16'h0000, 16'h0000, 1'b1, 16'd0, 16'h0000, 4'd8, 1'b0, 1'b0, 1'b0, 1'b0);
        checkOutput("pre after8 ptr", 64'(dut.ptr), 64'd9);
        @(negedge clk);

        // Limit and last coincide on beat 4: a normal completion, no preempt pulse.
        doReset();
        step("lim idle", 1'b0, 16'h0080, 16'h0000, 1'b1, 16'd0, 16'h0000, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        for (int k = 0; k < 4; k++) begin
            step($sformatf("lim beat%0d", k), 1'b0, 16'h0080, (k == 3) ? 16'h0080 : 16'h0000, 1'b1,
                 16'(k), 16'h0080, 4'd7, 1'b1, (k == 3), 1'b1, 1'b0);
            @(negedge clk);
        end
        step("lim nopulse", 1'b0, 16'h0000, 16'h0000, 1'b1, 16'd0, 16'h0000, 4'd7, 1'b0, 1'b0, 1'b0, 1'b0);
        checkOutput("lim ptr", 64'(dut.ptr), 64'd8);
        @(negedge clk);

        // Owner gap: owner 2 drops req for 3 cycles while 3 requests; then reset mid-packet.
        doReset();
        step("gap idle", 1'b0, 16'h0004, 16'h0000, 1'b1, 16'd0, 16'h0000, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        step("gap beat0", 1'b0, 16'h0004, 16'h0000, 1'b1, 16'd0, 16'h0004, 4'd2, 1'b1, 1'b0, 1'b1, 1'b0);
        @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            step($sformatf("gap hold%0d", k), 1'b0, 16'h0008, 16'h0000, 1'b1, 16'd1,
                 16'h0004, 4'd2, 1'b0, 1'b0, 1'b1, 1'b0);
            checkOutput($sformatf("gap hold%0d beats", k), 64'(dut.beats), 64'd1);
            @(negedge clk);
        end
        step("gap resume", 1'b0, 16'h000C, 16'h0000, 1'b1, 16'd1, 16'h0004, 4'd2, 1'b1, 1'b0, 1'b1, 1'b0);
        @(negedge clk);
        step("gap rstcyc", 1'b1, 16'h000C, 16'h0000, 1'b1, 16'd2, 16'h0004, 4'd2, 1'b1, 1'b0, 1'b1, 1'b0);
        checkOutput("gap rstcyc beats", 64'(dut.beats), 64'd2);
        @(negedge clk);
        step("gap postrst", 1'b0, 16'h000C, 16'h0000, 1'b1, 16'd3, 16'h0000, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        checkOutput("gap postrst ptr", 64'(dut.ptr), 64'd0);
        checkOutput("gap postrst beats", 64'(dut.beats), 64'd0);
        @(negedge clk);
        step("gap regrant", 1'b0, 16'h000C, 16'h0000, 1'b1, 16'd4, 16'h0004, 4'd2, 1'b1, 1'b0, 1'b1, 1'b0);
        @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
